// File: rtl/ip_pkg.sv
// Shared definitions for the Internet (RFC 1071) checksum blocks.
//   csum_t     : 16-bit ones' complement checksum word
//   CSUM_BYTES : checksum width in bytes on a byte-wide stream
//   ones_add   : 16-bit ones' complement addition with end-around carry
package ip_pkg;

    typedef logic [15:0] csum_t;

    localparam int unsigned CSUM_BYTES = 2;

    // The folded carry can never ripple out again: max FFFF+FFFF = 1FFFE -> FFFF.
    function automatic csum_t ones_add(csum_t a, csum_t b);
        logic [16:0] sum17;
        sum17 = 17'(a) + 17'(b);
        return sum17[15:0] + 16'(sum17[16]);
    endfunction

endpackage

// File: rtl/ip_checksum_calc.sv
// Byte-wide AXI-stream Internet checksum engine.
// Accumulates one packet of network-order bytes into a 16-bit ones'
// complement sum and emits the result as a 2-byte packet, MSB first.
// Ports:
//   clk, sreset          : clock, synchronous active-high reset
//   axis_i_*             : input byte stream (tready/tvalid/tlast/tdata)
//   axis_o_*             : output checksum stream (tready/tvalid/tlast/tdata)
// Parameters:
//   INVERT       : 1 = emit ~sum (generation), 0 = emit raw folded sum
//   ZERO_IS_FFFF : 1 = a final 0000 is emitted as FFFF
module ip_checksum_calc
    import ip_pkg::*;
#(
    parameter bit INVERT       = 1'b1,
    parameter bit ZERO_IS_FFFF = 1'b0
) (
    input  logic       clk,
    input  logic       sreset,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    input  logic       axis_o_tready,
    output logic       axis_o_tvalid,
    output logic       axis_o_tlast,
    output logic [7:0] axis_o_tdata
);

    localparam int unsigned RES_W = 8 * CSUM_BYTES;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        OUT_HI = 2'd1,
        OUT_LO = 2'd2
    } state_t;

    state_t           state_q, state_d;
    csum_t            acc_q, acc_d;
    logic [7:0]       hi_q, hi_d;
    logic             phase_q, phase_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [7:0]       tdata_q, tdata_d;

    csum_t            word_c;
    csum_t            sum_c;
    logic             beat_c;

    // Apply output polarity and the optional zero substitution.
    function automatic csum_t finalize(csum_t s);
        csum_t r;
        r = INVERT ? ~s : s;
        if (ZERO_IS_FFFF && (r == 16'h0000)) begin
            r = 16'hFFFF;
        end
        return r;
    endfunction

    // Ready is gated by reset so no beat is offered while the engine clears.
    assign axis_i_tready = (state_q == ACCUM) && !sreset;

    assign axis_o_tvalid = tvalid_q;
    assign axis_o_tlast  = tlast_q;
    assign axis_o_tdata  = tdata_q;

    // Odd trailing byte is padded with a zero low byte.
    assign beat_c = axis_i_tvalid && (state_q == ACCUM);
    assign word_c = phase_q ? {hi_q, axis_i_tdata} : {axis_i_tdata, 8'h00};
    assign sum_c  = ones_add(acc_q, word_c);

    // State register
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q  <= ACCUM;
            acc_q    <= 16'h0000;
            hi_q     <= 8'h00;
            phase_q  <= 1'b0;
            result_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            phase_q  <= phase_d;
            result_q <= result_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        phase_d  = phase_q;
        result_d = result_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;

        unique case (state_q)
            ACCUM: begin
                if (beat_c) begin
                    if (axis_i_tlast) begin
                        result_d = finalize(sum_c);
                        acc_d    = 16'h0000;
                        phase_d  = 1'b0;
                        state_d  = OUT_HI;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tdata_d  = result_d[15:8];
                    end else if (!phase_q) begin
                        hi_d    = axis_i_tdata;
                        phase_d = 1'b1;
                    end else begin
                        acc_d   = sum_c;
                        phase_d = 1'b0;
                    end
                end
            end
            OUT_HI: begin
                if (axis_o_tready) begin
                    state_d = OUT_LO;
                    tlast_d = 1'b1;
                    tdata_d = result_q[7:0];
                end
            end
            OUT_LO: begin
                if (axis_o_tready) begin
                    state_d  = ACCUM;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tdata_d  = 8'h00;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_ip_checksum_calc.sv
// Bench for ip_checksum_calc: three instances (generate, raw sum, zero->FFFF)
// share one input stream; a packet-level model predicts every output cycle.
module tb_ip_checksum_calc;

    logic       clk;
    logic       sreset;
    logic       i_tvalid;
    logic       i_tlast;
    logic [7:0] i_tdata;
    logic       o_tready;

    logic       i_rdy   [3];
    logic       o_valid [3];
    logic       o_last  [3];
    logic [7:0] o_data  [3];

    int checks   = 0;
    int failures = 0;

    ip_checksum_calc #(.INVERT(1'b1), .ZERO_IS_FFFF(1'b0)) u_gen (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(i_rdy[0]), .axis_i_tvalid(i_tvalid),
        .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_valid[0]),
        .axis_o_tlast(o_last[0]), .axis_o_tdata(o_data[0])
    );

    ip_checksum_calc #(.INVERT(1'b0), .ZERO_IS_FFFF(1'b0)) u_raw (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(i_rdy[1]), .axis_i_tvalid(i_tvalid),
        .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_valid[1]),
        .axis_o_tlast(o_last[1]), .axis_o_tdata(o_data[1])
    );

    ip_checksum_calc #(.INVERT(1'b1), .ZERO_IS_FFFF(1'b1)) u_zf (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(i_rdy[2]), .axis_i_tvalid(i_tvalid),
        .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_valid[2]),
        .axis_o_tlast(o_last[2]), .axis_o_tdata(o_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [7:0]  in_bytes[$];
    logic [15:0] sum_q[$];
    bit          out_phase = 1'b0;

    logic [15:0] got0[$];
    logic [15:0] got1[$];
    logic [15:0] got2[$];
    logic [7:0]  got_hi[3];

    // Plain integer sum of 16-bit words, folded at the end.
    function automatic logic [15:0] packet_sum(input logic [7:0] b[$]);
        int unsigned s = 0;
        int n = b.size();
        for (int k = 0; k < n; k += 2) begin
            s += {16'h0, b[k], (k + 1 < n) ? b[k+1] : 8'h00};
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    function automatic logic [15:0] inst_result(input logic [15:0] s, input int inst);
        logic [15:0] r;
        r = (inst == 1) ? s : ~s;
        if (inst == 2 && r == 16'h0000) r = 16'hFFFF;
        return r;
    endfunction

    task automatic check1(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle checker and model update
    always @(negedge clk) begin
        logic [15:0] r;
        for (int i = 0; i < 3; i++) begin
            check1($sformatf("tvalid[%0d]", i), 16'(o_valid[i]), 16'(sum_q.size() != 0));
            check1($sformatf("i_tready[%0d]", i), 16'(i_rdy[i]),
                   16'(!sreset && sum_q.size() == 0));
            if (sum_q.size() != 0 && o_valid[i] === 1'b1) begin
                r = inst_result(sum_q[0], i);
                check1($sformatf("tdata[%0d]", i), 16'(o_data[i]),
                       out_phase ? 16'(r[7:0]) : 16'(r[15:8]));
                check1($sformatf("tlast[%0d]", i), 16'(o_last[i]), 16'(out_phase));
            end
        end
        if (sreset) begin
            sum_q.delete();
            in_bytes.delete();
            out_phase = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (o_valid[i] === 1'b1 && o_tready) begin
                    if (o_last[i] !== 1'b1) got_hi[i] = o_data[i];
                    else begin
                        case (i)
                            0: got0.push_back({got_hi[i], o_data[i]});
                            1: got1.push_back({got_hi[i], o_data[i]});
                            default: got2.push_back({got_hi[i], o_data[i]});
                        endcase
                    end
                end
            end
            if (sum_q.size() != 0 && o_valid[0] === 1'b1 && o_tready) begin
                if (out_phase) begin
                    void'(sum_q.pop_front());
                    out_phase = 1'b0;
                end else begin
                    out_phase = 1'b1;
                end
            end
            if (i_tvalid && i_rdy[0] === 1'b1) begin
                in_bytes.push_back(i_tdata);
                if (i_tlast) begin
                    sum_q.push_back(packet_sum(in_bytes));
                    in_bytes.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pkt(input logic [7:0] b[$], input bit with_last);
        bit acc;
        int t;
        for (int k = 0; k < b.size(); k++) begin
            i_tvalid = 1'b1;
            i_tdata  = b[k];
            i_tlast  = with_last && (k == b.size() - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = (i_rdy[0] === 1'b1);
                t++;
            end
            if (!acc) begin
                failures++;
                $display("FAIL send_timeout: byte %0d not accepted got %0d expected 1", k, acc);
            end
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = 8'h00;
    endtask

    task automatic wait_drained();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sum_q.size() != 0 || i_rdy[0] !== 1'b1) && t < 200);
        checks++;
        if (t >= 200) begin
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", sum_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_word(input int inst, input logic [15:0] exp, input string name);
        logic [15:0] w;
        int n;
        n = (inst == 0) ? got0.size() : (inst == 1) ? got1.size() : got2.size();
        checks++;
        if (n == 0) begin
            failures++;
            $display("FAIL %s: got no word expected %h", name, exp);
        end else begin
            w = (inst == 0) ? got0.pop_front() : (inst == 1) ? got1.pop_front() : got2.pop_front();
            if (w !== exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", name, w, exp);
            end
        end
    endtask

    task automatic wait_valid(output bit seen);
        int t = 0;
        seen = 1'b0;
        while (!seen && t < 100) begin
            @(negedge clk);
            seen = (o_valid[0] === 1'b1);
            t++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_valid: tvalid got 0 expected 1");
        end
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        logic [7:0] hdr[$];
        logic [7:0] pkt[$];
        bit seen;

        hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};

        sreset   = 1'b1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = 8'h00;
        o_tready = 1'b1;
        got_hi   = '{8'h00, 8'h00, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_tvalid", 16'(o_valid[0]), 16'h0);
        check1("reset_tlast", 16'(o_last[0]), 16'h0);
        check1("reset_tdata", 16'(o_data[0]), 16'h00);
        check1("reset_tready", 16'(i_rdy[0]), 16'h0);
        @(posedge clk); #1;
        sreset = 1'b0;

        // Model pins
        check1("model_header", inst_result(packet_sum(hdr), 0), 16'hB861);
        pkt = '{8'hFF, 8'hFF, 8'h00, 8'h01};
        check1("model_fold", packet_sum(pkt), 16'h0001);

        send_pkt(hdr, 1'b1);
        wait_drained();
        expect_word(0, 16'hB861, "hdr_gen");
        expect_word(1, 16'h479E, "hdr_raw");
        expect_word(2, 16'hB861, "hdr_zf");

        pkt = '{8'h01, 8'h02, 8'h03};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'hFBFD, "odd3_gen");
        expect_word(1, 16'h0402, "odd3_raw");
        expect_word(2, 16'hFBFD, "odd3_zf");

        pkt = '{8'hAB};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'h54FF, "single_gen");
        expect_word(1, 16'hAB00, "single_raw");
        expect_word(2, 16'h54FF, "single_zf");

        pkt = '{8'hFF, 8'hFF, 8'h00, 8'h01};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'hFFFE, "carry_gen");
        expect_word(1, 16'h0001, "carry_raw");
        expect_word(2, 16'hFFFE, "carry_zf");

        pkt = '{8'hFF, 8'hFF};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'h0000, "zero_gen");
        expect_word(1, 16'hFFFF, "zero_raw");
        expect_word(2, 16'hFFFF, "zero_zf");

        // Backpressure with a second packet queued behind the first
        o_tready = 1'b0;
        fork
            begin
                logic [7:0] p2[$];
                p2 = '{8'h01, 8'h02};
                send_pkt(hdr, 1'b1);
                send_pkt(p2, 1'b1);
            end
            begin
                bit s;
                wait_valid(s);
                for (int k = 0; k < 5; k++) begin
                    check1("stall_tdata", 16'(o_data[0]), 16'h00B8);
                    check1("stall_i_tready", 16'(i_rdy[0]), 16'h0);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                o_tready = 1'b1;
            end
        join
        wait_drained();
        expect_word(0, 16'hB861, "bp_hdr_gen");
        expect_word(0, 16'hFEFD, "bp_second_gen");
        expect_word(1, 16'h479E, "bp_hdr_raw");
        expect_word(1, 16'h0102, "bp_second_raw");
        got2.delete();

        // Reset mid-packet discards the partial sum
        pkt = '{8'h45, 8'h00, 8'h00};
        send_pkt(pkt, 1'b0);
        sreset = 1'b1;
        @(posedge clk); #1;
        sreset = 1'b0;
        pkt = '{8'h01, 8'h02};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'hFEFD, "rst_pkt_gen");
        check1("rst_pkt_extra", 16'(got0.size()), 16'h0);
        got1.delete();
        got2.delete();

        // Reset while the low byte waits drops it
        o_tready = 1'b0;
        pkt = '{8'h01, 8'h02};
        send_pkt(pkt, 1'b1);
        wait_valid(seen);
        @(posedge clk); #1;
        o_tready = 1'b1;
        @(posedge clk); #1;
        o_tready = 1'b0;
        sreset = 1'b1;
        @(posedge clk); #1;
        sreset = 1'b0;
        @(negedge clk);
        check1("rst_lo_tvalid", 16'(o_valid[0]), 16'h0);
        @(posedge clk); #1;
        o_tready = 1'b1;
        pkt = '{8'hAB};
        send_pkt(pkt, 1'b1);
        wait_drained();
        expect_word(0, 16'h54FF, "after_rst_gen");
        check1("after_rst_extra", 16'(got0.size()), 16'h0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
